// File: rtl/gen_elastic_pipe_if.sv
// Valid/ready handshake bundle for gen_elastic_pipe: upstream push side and downstream pop side.
// The master drives words in and accepts them out; the slave is the pipe itself.
interface gen_elastic_pipe_if #(
  parameter int DW = 32
);
  logic          in_valid;
  logic          in_ready;
  logic [DW-1:0] din;
  logic          out_valid;
  logic          out_ready;
  logic [DW-1:0] qout;

  modport master (
    output in_valid, din, out_ready,
    input  in_ready, out_valid, qout
  );

  modport slave (
    input  in_valid, din, out_ready,
    output in_ready, out_valid, qout
  );
endinterface

// File: rtl/gen_elastic_pipe.sv
// Bubble-collapsing elastic register pipeline of DEPTH stages with a global stall,
// a synchronous flush, a default output value and a registered occupancy count.
module gen_elastic_pipe #(
  parameter int DW    = 32,
  parameter int DEPTH = 2
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         hold_en,
  input  logic                         flush,
  input  logic [DW-1:0]                def_val,
  gen_elastic_pipe_if.slave            bus,
  output logic [$clog2(DEPTH+1)-1:0]   occupancy
);

  localparam int OW = $clog2(DEPTH + 1);

  if (DEPTH < 1 || DEPTH > 8) begin : g_bad_depth
    $error("gen_elastic_pipe: DEPTH must be in 1..8");
  end

  logic             run;
  logic [DEPTH:0]   en;
  logic [DEPTH-1:0] v;
  logic [DW-1:0]    d [DEPTH];
  logic             push;
  logic             pop;
  logic [OW-1:0]    occ_reg;
  logic [OW-1:0]    occ_next;

  assign run = !hold_en && !flush;

  // Ready ripples from the output back to stage 0; an empty stage breaks the stall chain.
  always_comb begin
    en        = '0;
    en[DEPTH] = bus.out_ready;
    for (int k = DEPTH - 1; k >= 0; k--) begin
      en[k] = run && (!v[k] || en[k+1]);
    end
  end

  genvar gi;
  generate
    for (gi = 0; gi < DEPTH; gi++) begin : g_stage
      logic          v_reg;
      logic [DW-1:0] d_reg;
      logic          src_v;
      logic [DW-1:0] src_d;

      if (gi == 0) begin : g_src_in
        assign src_v = bus.in_valid;
        assign src_d = bus.din;
      end else begin : g_src_prev
        assign src_v = v[gi-1];
        assign src_d = d[gi-1];
      end

      // Data only loads with a valid word so bubbles leave the register untouched.
      always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
          v_reg <= 1'b0;
          d_reg <= '0;
        end else begin
          if (flush) begin
            v_reg <= 1'b0;
          end else if (en[gi]) begin
            v_reg <= src_v;
          end
          if (en[gi] && src_v) begin
            d_reg <= src_d;
          end
        end
      end

      assign v[gi] = v_reg;
      assign d[gi] = d_reg;
    end
  endgenerate

  assign bus.in_ready  = en[0];
  assign bus.out_valid = v[DEPTH-1] && run;
  assign bus.qout      = bus.out_valid ? d[DEPTH-1] : def_val;

  assign push     = bus.in_valid && en[0];
  assign pop      = bus.out_valid && bus.out_ready;
  assign occ_next = flush ? '0 : (occ_reg + OW'(push) - OW'(pop));

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      occ_reg <= '0;
    end else begin
      occ_reg <= occ_next;
    end
  end

  assign occupancy = occ_reg;

endmodule

// File: tb/tb_gen_elastic_pipe.sv
// Drives pipes of DEPTH 1..4 with shared directed and random stimulus; each pipe is checked
// every cycle against a word/position model, plus hand-computed expectations per scenario.
module tb_gen_elastic_pipe;

  localparam int DW = 16;
  localparam int NP = 4;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          hold_en = 1'b0;
  logic          flush = 1'b0;
  logic [DW-1:0] def_val = 16'hDEAD;
  logic          in_valid = 1'b0;
  logic [DW-1:0] din = '0;
  logic          out_ready = 1'b0;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  genvar gi;
  generate
    for (gi = 0; gi < NP; gi++) begin : g_dut
      localparam int D = gi + 1;

      gen_elastic_pipe_if #(.DW(DW)) bus ();
      logic [$clog2(D+1)-1:0] occ;

      assign bus.in_valid  = in_valid;
      assign bus.din       = din;
      assign bus.out_ready = out_ready;

      gen_elastic_pipe #(.DW(DW), .DEPTH(D)) u_dut (
        .clk       (clk),
        .rst       (rst),
        .hold_en   (hold_en),
        .flush     (flush),
        .def_val   (def_val),
        .bus       (bus),
        .occupancy (occ)
      );

      // Model: words in arrival order, each tagged with the stage it currently sits in.
      logic [DW-1:0] m_data [$];
      int            m_pos  [$];
      int            n;
      bit            m_push;
      bit            mv [8];
      int            old_pos [8];

      initial begin
        forever begin
          @(posedge clk or negedge rst);
          if (!rst || flush) begin
            m_data.delete();
            m_pos.delete();
          end else if (!hold_en) begin
            n = m_pos.size();
            m_push = in_valid && (n < D || out_ready);
            for (int i = 0; i < n; i++) old_pos[i] = m_pos[i];
            // A word advances if a gap lies just ahead of it or the word ahead advances.
            for (int i = 0; i < n; i++) begin
              if (i == 0) mv[i] = (old_pos[0] < D - 1) || out_ready;
              else        mv[i] = (old_pos[i] + 1 < old_pos[i-1]) || mv[i-1];
            end
            for (int i = 0; i < n; i++) if (mv[i]) m_pos[i] = old_pos[i] + 1;
            if (n > 0 && m_pos[0] == D) begin
              void'(m_pos.pop_front());
              void'(m_data.pop_front());
            end
            if (m_push) begin
              m_pos.push_back(0);
              m_data.push_back(din);
            end
          end
        end
      end

      bit            e_ov;
      bit            e_ir;
      logic [DW-1:0] e_q;

      initial begin
        forever begin
          @(negedge clk);
          e_ov = rst && m_pos.size() > 0 && m_pos[0] == D - 1 && !hold_en && !flush;
          e_q  = e_ov ? m_data[0] : def_val;
          e_ir = !hold_en && !flush && (m_pos.size() < D || out_ready);
          check($sformatf("D%0d model in_ready", D),  64'(bus.in_ready),  64'(e_ir));
          check($sformatf("D%0d model out_valid", D), 64'(bus.out_valid), 64'(e_ov));
          check($sformatf("D%0d model qout", D),      64'(bus.qout),      64'(e_q));
          check($sformatf("D%0d model occupancy", D), 64'(occ),           64'(m_pos.size()));
        end
      end
    end
  endgenerate

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic peek();
    #2;
  endtask

  task automatic idle_drain();
    in_valid  = 1'b0;
    out_ready = 1'b1;
    hold_en   = 1'b0;
    flush     = 1'b0;
    repeat (10) cyc();
  endtask

  initial begin
    repeat (3) cyc();
    check("reset D2 occupancy", 64'(g_dut[1].occ), 64'd0);
    check("reset D2 out_valid", 64'(g_dut[1].bus.out_valid), 64'd0);
    check("reset D2 qout", 64'(g_dut[1].bus.qout), 64'hDEAD);
    check("reset D2 in_ready", 64'(g_dut[1].bus.in_ready), 64'd1);
    rst = 1'b1;
    cyc();

    // Streaming through DEPTH=2
    out_ready = 1'b1;
    in_valid = 1'b1; din = 16'h00A1; cyc();
    din = 16'h00A2; peek();
    check("stream D2 out_valid early", 64'(g_dut[1].bus.out_valid), 64'd0);
    check("stream D2 occ 1", 64'(g_dut[1].occ), 64'd1);
    cyc();
    din = 16'h00A3; peek();
    check("stream D2 qout A1", 64'(g_dut[1].bus.qout), 64'h00A1);
    check("stream D2 occ 2", 64'(g_dut[1].occ), 64'd2);
    cyc();
    in_valid = 1'b0; peek();
    check("stream D2 qout A2", 64'(g_dut[1].bus.qout), 64'h00A2);
    check("stream D2 occ steady", 64'(g_dut[1].occ), 64'd2);
    cyc(); peek();
    check("stream D2 qout A3", 64'(g_dut[1].bus.qout), 64'h00A3);
    cyc(); peek();
    check("stream D2 empty out_valid", 64'(g_dut[1].bus.out_valid), 64'd0);
    idle_drain();

    // Fill DEPTH=4 against a stalled sink, then push and pop together
    out_ready = 1'b0; in_valid = 1'b1; din = 16'h00B1; peek();
    check("fill D4 in_ready empty", 64'(g_dut[3].bus.in_ready), 64'd1);
    cyc(); din = 16'h00B2;
    cyc(); din = 16'h00B3;
    cyc(); din = 16'h00B4;
    cyc(); din = 16'h00B5; peek();
    check("fill D4 in_ready full", 64'(g_dut[3].bus.in_ready), 64'd0);
    check("fill D4 occ 4", 64'(g_dut[3].occ), 64'd4);
    check("fill D4 qout B1", 64'(g_dut[3].bus.qout), 64'h00B1);
    cyc(); peek();
    check("fill D4 hold occ", 64'(g_dut[3].occ), 64'd4);
    check("fill D4 hold qout", 64'(g_dut[3].bus.qout), 64'h00B1);
    out_ready = 1'b1; peek();
    check("full D4 in_ready with sink", 64'(g_dut[3].bus.in_ready), 64'd1);
    cyc(); din = 16'h00B6; peek();
    check("pushpop D4 occ", 64'(g_dut[3].occ), 64'd4);
    check("pushpop D4 qout B2", 64'(g_dut[3].bus.qout), 64'h00B2);
    cyc(); in_valid = 1'b0; peek();
    check("pushpop D4 occ again", 64'(g_dut[3].occ), 64'd4);
    check("pushpop D4 qout B3", 64'(g_dut[3].bus.qout), 64'h00B3);
    idle_drain();

    // Stall DEPTH=3 with two words inside
    in_valid = 1'b1; din = 16'h00C1; cyc();
    din = 16'h00C2; cyc();
    in_valid = 1'b0; hold_en = 1'b1;
    for (int i = 0; i < 3; i++) begin
      peek();
      check("hold D3 out_valid", 64'(g_dut[2].bus.out_valid), 64'd0);
      check("hold D3 qout", 64'(g_dut[2].bus.qout), 64'hDEAD);
      check("hold D3 in_ready", 64'(g_dut[2].bus.in_ready), 64'd0);
      check("hold D3 occ", 64'(g_dut[2].occ), 64'd2);
      cyc();
    end
    hold_en = 1'b0;
    cyc(); peek();
    check("hold D3 resume C1", 64'(g_dut[2].bus.qout), 64'h00C1);
    cyc(); peek();
    check("hold D3 resume C2", 64'(g_dut[2].bus.qout), 64'h00C2);
    idle_drain();

    // Flush a full DEPTH=4 while a word waits at din
    out_ready = 1'b0; in_valid = 1'b1;
    for (int i = 0; i < 4; i++) begin
      din = 16'h00D0 + 16'(i);
      cyc();
    end
    flush = 1'b1; din = 16'h0055; peek();
    check("flush D4 in_ready", 64'(g_dut[3].bus.in_ready), 64'd0);
    check("flush D4 out_valid", 64'(g_dut[3].bus.out_valid), 64'd0);
    cyc();
    flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1; peek();
    check("flush D4 occ", 64'(g_dut[3].occ), 64'd0);
    for (int i = 0; i < 4; i++) begin
      check("flush D4 stays empty", 64'(g_dut[3].bus.out_valid), 64'd0);
      cyc(); peek();
    end
    idle_drain();

    // Asynchronous reset with one word in DEPTH=2 stage 0
    in_valid = 1'b1; din = 16'h00E1; cyc();
    in_valid = 1'b0;
    #2 rst = 1'b0;
    #1;
    check("async rst D2 occ", 64'(g_dut[1].occ), 64'd0);
    check("async rst D2 out_valid", 64'(g_dut[1].bus.out_valid), 64'd0);
    check("async rst D2 qout", 64'(g_dut[1].bus.qout), 64'hDEAD);
    check("async rst D2 in_ready", 64'(g_dut[1].bus.in_ready), 64'd1);
    #3 rst = 1'b1;
    cyc(); peek();
    check("async rst D2 word dropped", 64'(g_dut[1].bus.out_valid), 64'd0);
    in_valid = 1'b1; din = 16'h00F1; cyc();
    in_valid = 1'b0; peek();
    check("post rst D2 latency early", 64'(g_dut[1].bus.out_valid), 64'd0);
    cyc(); peek();
    check("post rst D2 out_valid", 64'(g_dut[1].bus.out_valid), 64'd1);
    check("post rst D2 qout F1", 64'(g_dut[1].bus.qout), 64'h00F1);
    idle_drain();

    // Random traffic against the per-pipe models
    for (int c = 0; c < 10000; c++) begin
      in_valid  = 1'($urandom_range(0, 1));
      out_ready = 1'($urandom_range(0, 1));
      hold_en   = 1'($urandom_range(0, 1));
      flush     = ($urandom_range(0, 49) == 0);
      din       = DW'($urandom);
      def_val   = DW'($urandom);
      cyc();
    end
    idle_drain();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
